// File: rtl/wallace_cpa_serial.sv
// wallace_cpa_serial: bit-serial carry-propagate adder that resolves the
// redundant sum/carry rows of the Wallace-tree compressor into the binary
// product, one bit per clock through a single full-adder cell.
module wallace_cpa_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] sum_row_i,
  input  logic [WIDTH-1:0] carry_row_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] a_sh_q,      a_sh_d;
  logic [WIDTH-1:0] b_sh_q,      b_sh_d;
  logic             c_q,         c_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             overflow_q,  overflow_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             fa_s_c;
  logic             fa_co_c;

  // Single full-adder cell operating on the current LSBs and the carry flop.
  always_comb begin
    fa_s_c  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    fa_co_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  end

  // Next-state and datapath update; handshake flags track the next state so
  // they are available as plain flop outputs.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_sh_d  = sum_row_i;
          b_sh_d  = carry_row_i;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d = {fa_s_c, result_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        c_d      = fa_co_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          overflow_d = fa_co_c;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_wallace_cpa_serial.sv
// tb_wallace_cpa_serial: directed vector table, hand-written corner
// sequences and a randomized handshake regression at WIDTH=8 and WIDTH=16.
module tb_wallace_cpa_serial;

  logic clk;
  logic rst_n;

  logic        iv8, irdy8, ov8, ordy8, of8;
  logic [7:0]  sr8, cr8, res8;
  logic        iv16, irdy16, ov16, ordy16, of16;
  logic [15:0] sr16, cr16, res16;

  int errors = 0;
  int checks = 0;

  wallace_cpa_serial #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(iv8), .in_ready_o(irdy8),
    .sum_row_i(sr8), .carry_row_i(cr8),
    .out_valid_o(ov8), .out_ready_i(ordy8),
    .result_o(res8), .overflow_o(of8)
  );

  wallace_cpa_serial #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(iv16), .in_ready_o(irdy16),
    .sum_row_i(sr16), .carry_row_i(cr16),
    .out_valid_o(ov16), .out_ready_i(ordy16),
    .result_o(res16), .overflow_o(of16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [7:0] c;
    logic [7:0] exp_res;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Run one operation on the 8-bit DUT (assumed idle); returns result and latency.
  task automatic op8(input logic [7:0] s, input logic [7:0] c,
                     output logic [7:0] r, output logic o, output int lat);
    @(negedge clk);
    sr8 = s; cr8 = c; iv8 = 1'b1; ordy8 = 1'b0;
    @(posedge clk);
    #1;
    iv8 = 1'b0; sr8 = 8'($urandom); cr8 = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = res8; o = of8;
    ordy8 = 1'b1;
    @(posedge clk);
    #1;
    ordy8 = 1'b0;
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] r;
    logic       o;
    int         lat;
    int         ov_seen;
    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    logic [8:0]  e8;
    logic [16:0] e16;
    int acc8, done8, acc16, done16, cyc;

    vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 8'hFF, 1'b0};

    iv16 = 1'b0; ordy16 = 1'b0; sr16 = '0; cr16 = '0;
    ordy8 = 1'b0;

    // Reset with in_valid high and random rows
    rst_n = 1'b0; iv8 = 1'b1; sr8 = 8'($urandom); cr8 = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(irdy8), 32'd1);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_result", 32'(res8), 32'h00);
    chk("rst_overflow", 32'(of8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(irdy8), 32'd1);
    chk("post_rst_no_out", 32'(ov8), 32'd0);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].s, vecs[i].c, r, o, lat);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d_overflow", i), 32'(o), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("vec%0d_ready_back", i), 32'(irdy8), 32'd1);
    end

    // Backpressure: DONE holds while out_ready low and in_valid pulses
    @(negedge clk);
    sr8 = 8'h35; cr8 = 8'h4A; iv8 = 1'b1; ordy8 = 1'b0;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      iv8 = k[0]; sr8 = 8'h11 + 8'(k); cr8 = 8'h22;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_result", k), 32'(res8), 32'h7F);
      chk($sformatf("bp%0d_in_ready", k), 32'(irdy8), 32'd0);
      chk($sformatf("bp%0d_out_valid", k), 32'(ov8), 32'd1);
    end
    ordy8 = 1'b1; iv8 = 1'b1; sr8 = 8'h01; cr8 = 8'h02;
    @(posedge clk);
    #1;
    chk("bp_handshake_idle", 32'(irdy8), 32'd1);
    chk("bp_handshake_out", 32'(ov8), 32'd0);
    ordy8 = 1'b0;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    chk("bp_next_accepted", 32'(irdy8), 32'd0);
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_next_latency", 32'(lat), 32'd8);
    chk("bp_next_result", 32'(res8), 32'h03);
    ordy8 = 1'b1;
    @(posedge clk);
    #1;
    ordy8 = 1'b0;

    // Reset three edges into RUN
    @(negedge clk);
    sr8 = 8'h77; cr8 = 8'h11; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_result", 32'(res8), 32'h00);
    chk("midrst_overflow", 32'(of8), 32'd0);
    chk("midrst_in_ready", 32'(irdy8), 32'd1);
    chk("midrst_out_valid", 32'(ov8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (ov8) ov_seen++;
    end
    chk("midrst_no_out", 32'(ov_seen), 32'd0);
    op8(8'h12, 8'h34, r, o, lat);
    chk("midrst_follow_result", 32'(r), 32'h46);
    chk("midrst_follow_overflow", 32'(o), 32'd0);

    // Random regression on both widths concurrently
    acc8 = 0; done8 = 0; acc16 = 0; done16 = 0; cyc = 0;
    while ((done8 < 1000 || done16 < 1000) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      iv8 = (acc8 < 1000) && ($urandom_range(0, 1) == 1);
      sr8 = 8'($urandom); cr8 = 8'($urandom);
      ordy8 = ($urandom_range(0, 1) == 1);
      if (iv8 && irdy8) begin
        q8.push_back({1'b0, sr8} + {1'b0, cr8});
        acc8++;
      end
      if (ov8 && ordy8) begin
        if (q8.size() == 0) begin
          chk("rand8_unexpected_output", 32'd1, 32'd0);
        end else begin
          e8 = q8.pop_front();
          chk("rand8_sum", 32'({of8, res8}), 32'(e8));
        end
        done8++;
      end
      iv16 = (acc16 < 1000) && ($urandom_range(0, 1) == 1);
      sr16 = 16'($urandom); cr16 = 16'($urandom);
      ordy16 = ($urandom_range(0, 1) == 1);
      if (iv16 && irdy16) begin
        q16.push_back({1'b0, sr16} + {1'b0, cr16});
        acc16++;
      end
      if (ov16 && ordy16) begin
        if (q16.size() == 0) begin
          chk("rand16_unexpected_output", 32'd1, 32'd0);
        end else begin
          e16 = q16.pop_front();
          chk("rand16_sum", 32'({of16, res16}), 32'(e16));
        end
        done16++;
      end
    end
    @(negedge clk);
    iv8 = 1'b0; ordy8 = 1'b0; iv16 = 1'b0; ordy16 = 1'b0;
    chk("rand8_outputs", 32'(done8), 32'd1000);
    chk("rand8_accepted", 32'(acc8), 32'd1000);
    chk("rand8_queue_empty", 32'(q8.size()), 32'd0);
    chk("rand16_outputs", 32'(done16), 32'd1000);
    chk("rand16_accepted", 32'(acc16), 32'd1000);
    chk("rand16_queue_empty", 32'(q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wallace_cpa_serial.md
# wallace_cpa_serial

Serial carry-propagate adder that forms the final stage of the Wallace-tree multiplier. It accepts the two redundant rows (sum row and carry row) produced by the full/half-adder compression tree and resolves them into the binary product. It processes one bit per clock through a single full-adder cell, with valid/ready handshakes on both sides. It sits directly downstream of the compression tree and upstream of the product consumer.

## Interface
- WIDTH, 16, width of each input row and of the result; legal range WIDTH >= 2
- clk  input  1  sole clock; all state changes on rising edge
- rst_n  input  1  one clock; reset is synchronous and active-low
- in_valid  input  1  sum_row/carry_row valid this cycle
- in_ready  output  1  block can accept a new operand pair
- sum_row  input  WIDTH  sum row from compression tree
- carry_row  input  WIDTH  carry row from tree, already weight-aligned to sum_row
- out_valid  output  1  result/overflow valid
- out_ready  input  1  consumer accepts result this cycle
- result  output  WIDTH  (sum_row + carry_row) mod 2^WIDTH
- overflow  output  1  carry out of bit WIDTH-1

## Operation
- State register has three states: IDLE, RUN, DONE.
- Internal registers: a_sh and b_sh (WIDTH each), c (carry flop), cnt (ceil(log2 WIDTH) bits), result, overflow.
- Reset (rst_n low at a rising edge):
  - state=IDLE
  - result=0, overflow=0
  - a_sh=b_sh=0, c=0, cnt=0
  - in_valid is ignored while rst_n is low.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only, with no combinational path from inputs.
- IDLE: when in_valid && in_ready at an edge:
  - a_sh<=sum_row, b_sh<=carry_row, c<=0, cnt<=0
  - state<=RUN
- RUN: each edge evaluates a full adder on (a_sh[0], b_sh[0], c), giving sum s and carry co.
  - result <= {s, result[WIDTH-1:1]}, so the LSB enters first and arrives at bit 0 after WIDTH shifts.
  - a_sh, b_sh shift right by 1, with zero fill.
  - c <= co; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: overflow <= co, state <= DONE.
- DONE: result and overflow hold stable. When out_ready is high at an edge, state<=IDLE. result and overflow keep their values until the next RUN overwrites them.
- Arithmetic: unsigned, modulo 2^WIDTH. Bits of carry_row above WIDTH-1 do not exist; the tree must truncate them.
- sum_row and carry_row are sampled only on the accept edge. Changes at any other time have no effect.

## Timing
- Latency: the accept edge is E0. RUN occupies edges E1..E(WIDTH). out_valid is high from just after E(WIDTH), i.e. exactly WIDTH cycles after accept.
- Throughput: one operation per WIDTH+2 cycles at best (accept, WIDTH RUN edges, output handshake edge). No overlap of input and output handshakes.
- Backpressure: DONE persists indefinitely while out_ready is low.
  - in_ready stays 0 and in_valid is ignored.
  - result and overflow do not change.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Reset mid-RUN or mid-DONE:
  - The next edge with rst_n low returns the block to reset values.
  - The in-flight operation is discarded and out_valid is never raised for it.
- Reset and in_valid asserted together: reset wins and nothing is accepted.

## Test plan
All scenarios use WIDTH=8 unless stated otherwise.
- Reset: hold rst_n low for 2 edges with in_valid=1 and random rows. Required: in_ready=1, out_valid=0, result=0x00, overflow=0, and no operation starts after rst_n rises until in_valid is sampled high again.
- Basic add: sum_row=0x0F, carry_row=0x01, out_ready=1. Required: out_valid rises exactly 8 cycles after the accept edge, with result=0x10 and overflow=0; in_ready returns to 1 on the following cycle.
- Full carry ripple: sum_row=0xFF, carry_row=0x01. Required: result=0x00, overflow=1. Then sum_row=0x80, carry_row=0x80. Required: result=0x00, overflow=1.
- Backpressure: sum_row=0x35, carry_row=0x4A, out_ready low for 5 cycles after out_valid while in_valid pulses with other data. Required: result=0x7F stays stable, in_ready=0, no new operation is accepted. After out_ready goes high, one handshake completes and the next input is accepted.
- Reset mid-run: deassert rst_n 3 edges into RUN. Required: all outputs return to reset values at that edge, and out_valid stays 0 for the aborted operation. A following operation with 0x12+0x34 gives 0x46.
- Random regression with WIDTH=8 and WIDTH=16: 1000 operand pairs with random in_valid and out_ready toggling. Each {overflow, result} must equal the sum_row+carry_row reference model, with no result lost or duplicated.
